// File: rtl/mips_pkg.sv
// Shared constants for the MIPS-style datapath register file.
package mips_pkg;

   // Default register-address width (32 architectural registers).
   localparam int REG_ADDR_W = 5;

   // Default register and data-bus width.
   localparam int DATA_W     = 32;

   // Index of the hardwired-zero register.
   localparam int ZERO_REG   = 0;

endpackage : mips_pkg

// File: rtl/mips_register_file_rf_reg.sv
// Single register-file entry: BUS_W-bit register with async clear and write enable.
module rf_reg
   import mips_pkg::*;
#(
   parameter int BUS_W = DATA_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [BUS_W-1:0] d,
   output logic [BUS_W-1:0] q
);

   // Clear immediately on reset; otherwise capture write data when enabled.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q <= '0;
      end else if (en) begin
         q <= d;
      end
   end

endmodule : rf_reg

// File: rtl/mips_register_file.sv
// Two-read, one-write register file; register 0 is hardwired to zero.
// Reads are combinational with no write bypass: a same-cycle read of the
// register being written returns the old value until the clock edge.
module mips_register_file
   import mips_pkg::*;
#(
   parameter int ADDR  = REG_ADDR_W,
   parameter int BUS_W = DATA_W
) (
   input  logic             reloj_cucu,
   input  logic             reset,
   input  logic             r_write,
   input  logic [ADDR-1:0]  rd_addr,
   input  logic [BUS_W-1:0] rd_w_data,
   input  logic [ADDR-1:0]  rs_addr,
   input  logic [ADDR-1:0]  rt_addr,
   output logic [BUS_W-1:0] rs_data,
   output logic [BUS_W-1:0] rt_data
);

   localparam int            NREG      = 1 << ADDR;
   localparam logic [ADDR-1:0] ZERO_ADDR = ADDR'(ZERO_REG);

   // One enable per real register; entry 0 has no storage and no enable.
   logic [NREG-1:1]  wr_en;
   logic [BUS_W-1:0] regs [NREG];

   // Register 0 has no storage; it feeds a constant zero into the read muxes.
   assign regs[0] = '0;

   // Write-address decoder: one-hot enables gated by r_write.
   always_comb begin
      wr_en = '0;
      for (int i = 1; i < NREG; i++) begin
         wr_en[i] = r_write && (rd_addr == ADDR'(i));
      end
   end

   // Storage entries 1 .. 2^ADDR-1.
   for (genvar g = 1; g < NREG; g++) begin : g_reg
      rf_reg #(
         .BUS_W (BUS_W)
      ) u_rf_reg (
         .clk (reloj_cucu),
         .rst (reset),
         .en  (wr_en[g]),
         .d   (rd_w_data),
         .q   (regs[g])
      );
   end

   // Read port A: combinational mux with zero override for address 0.
   always_comb begin
      rs_data = '0;
      if (rs_addr != ZERO_ADDR) begin
         rs_data = regs[rs_addr];
      end
   end

   // Read port B: combinational mux with zero override for address 0.
   always_comb begin
      rt_data = '0;
      if (rt_addr != ZERO_ADDR) begin
         rt_data = regs[rt_addr];
      end
   end

endmodule : mips_register_file

// File: tb/tb_mips_register_file.sv
// Directed bench for mips_register_file with a read-expectation scoreboard.
module tb_mips_register_file;

   localparam int ADDR  = 5;
   localparam int BUS_W = 32;
   localparam int NREG  = 1 << ADDR;

   logic             reloj_cucu;
   logic             reset;
   logic             r_write;
   logic [ADDR-1:0]  rd_addr;
   logic [BUS_W-1:0] rd_w_data;
   logic [ADDR-1:0]  rs_addr;
   logic [ADDR-1:0]  rt_addr;
   logic [BUS_W-1:0] rs_data;
   logic [BUS_W-1:0] rt_data;

   int tests = 0;
   int fails = 0;

   logic [BUS_W-1:0] model [NREG];
   logic [BUS_W-1:0] exp_q [$];

   mips_register_file #(
      .ADDR  (ADDR),
      .BUS_W (BUS_W)
   ) dut (
      .reloj_cucu (reloj_cucu),
      .reset      (reset),
      .r_write    (r_write),
      .rd_addr    (rd_addr),
      .rd_w_data  (rd_w_data),
      .rs_addr    (rs_addr),
      .rt_addr    (rt_addr),
      .rs_data    (rs_data),
      .rt_data    (rt_data)
   );

   initial reloj_cucu = 1'b0;
   always #5 reloj_cucu = ~reloj_cucu;

   function automatic logic [BUS_W-1:0] expv(input logic [ADDR-1:0] a);
      return (a == '0) ? '0 : model[a];
   endfunction

   task automatic clear_model();
      for (int i = 0; i < NREG; i++) model[i] = '0;
   endtask

   // Drive both read addresses and queue the values they must return.
   task automatic apply_read(input logic [ADDR-1:0] a, input logic [ADDR-1:0] b);
      rs_addr = a;
      rt_addr = b;
      exp_q.push_back(expv(a));
      exp_q.push_back(expv(b));
   endtask

   // Pop the two queued expectations and compare against the read ports.
   task automatic sample(input string tag);
      logic [BUS_W-1:0] e_rs, e_rt;
      if (exp_q.size() < 2) begin
         tests++;
         fails++;
         $error("FAIL %s: scoreboard empty, size=%0d required>=2", tag, exp_q.size());
         return;
      end
      e_rs = exp_q.pop_front();
      e_rt = exp_q.pop_front();
      tests++;
      assert (rs_data === e_rs) else begin
         fails++;
         $error("FAIL %s rs[%0d]: got %h expected %h", tag, rs_addr, rs_data, e_rs);
      end
      tests++;
      assert (rt_data === e_rt) else begin
         fails++;
         $error("FAIL %s rt[%0d]: got %h expected %h", tag, rt_addr, rt_data, e_rt);
      end
   endtask

   // One write cycle: drive at the falling edge, commit in the model at the rising edge.
   task automatic write_edge(input logic we, input logic [ADDR-1:0] a,
                             input logic [BUS_W-1:0] d);
      @(negedge reloj_cucu);
      r_write   = we;
      rd_addr   = a;
      rd_w_data = d;
      @(posedge reloj_cucu);
      if (we && a != '0 && !reset) model[a] = d;
      #1;
      r_write = 1'b0;
   endtask

   initial begin
      reset     = 1'b1;
      r_write   = 1'b1;
      rd_addr   = 5'd5;
      rd_w_data = 32'hDEADBEEF;
      rs_addr   = '0;
      rt_addr   = '0;
      clear_model();

      // Reset hold: a write under reset is ignored.
      @(posedge reloj_cucu);
      #1;
      apply_read(5'd5, 5'd5);
      #1 sample("reset_hold_r5");
      for (int i = 0; i < NREG; i++) begin
         apply_read(ADDR'(i), ADDR'(NREG - 1 - i));
         #1 sample("reset_all");
      end

      // Deassert reset; write 7 with a same-cycle read before and after the edge.
      @(negedge reloj_cucu);
      reset     = 1'b0;
      r_write   = 1'b1;
      rd_addr   = 5'd7;
      rd_w_data = 32'h12345678;
      apply_read(5'd7, 5'd7);
      #1 sample("rw7_before_edge");
      @(posedge reloj_cucu);
      model[7] = 32'h12345678;
      #1;
      r_write = 1'b0;
      apply_read(5'd7, 5'd7);
      #1 sample("rw7_after_edge");

      // Write to register 0 is discarded.
      write_edge(1'b1, 5'd0, 32'hFFFFFFFF);
      apply_read(5'd0, 5'd0);
      #1 sample("reg0_zero");

      // Write enable low: register 3 keeps its prior value.
      write_edge(1'b1, 5'd3, 32'h00000033);
      write_edge(1'b0, 5'd3, 32'hAAAA5555);
      apply_read(5'd3, 5'd7);
      #1 sample("we_low_r3");

      // Sweep: value i into register i, read i and 31-i.
      for (int i = 1; i < NREG; i++) write_edge(1'b1, ADDR'(i), BUS_W'(i));
      for (int i = 0; i < NREG; i++) begin
         apply_read(ADDR'(i), ADDR'(NREG - 1 - i));
         #1 sample("sweep");
      end

      // Async reset between edges clears outputs before the next rising edge.
      @(negedge reloj_cucu);
      #1;
      reset = 1'b1;
      clear_model();
      apply_read(5'd9, 5'd31);
      #1 sample("async_reset_mid");

      // Reset and write at the same edge: reset wins.
      r_write   = 1'b1;
      rd_addr   = 5'd9;
      rd_w_data = 32'h00000077;
      @(posedge reloj_cucu);
      #1;
      apply_read(5'd9, 5'd1);
      #1 sample("reset_vs_write");

      // After deassert, the first rising edge performs the write.
      @(negedge reloj_cucu);
      reset     = 1'b0;
      r_write   = 1'b1;
      rd_addr   = 5'd9;
      rd_w_data = 32'h00000055;
      @(posedge reloj_cucu);
      model[9] = 32'h00000055;
      #1;
      r_write = 1'b0;
      apply_read(5'd9, 5'd30);
      #1 sample("first_write_after_reset");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule : tb_mips_register_file
